// File: rtl/mdim_pkg.sv
// Shared packed-pair layout used by the pair packer and the unpacker.
package mdim_pkg;

    parameter int FIELD_W_DEFAULT = 4;

    // b is declared first so that a occupies the least significant bits.
    typedef struct packed {
        logic [FIELD_W_DEFAULT-1:0] b;
        logic [FIELD_W_DEFAULT-1:0] a;
    } pair_t;

endpackage

// File: rtl/mdim_pair_fifo.sv
// Small synchronous FIFO for packed pair words; the head entry is read
// straight out of storage with no output register.
module mdim_pair_fifo
    import mdim_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEFAULT,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*FIELD_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*FIELD_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [2*FIELD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;

    // Handshake flags depend only on the registered occupancy.
    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mdim_unpack.sv
// Receive side of the packed-pair link: buffers {b, a} words and presents the
// fields separately. Define MDIM_UNPACK_STATS_EN to add word_cnt / ovf_seen.
module mdim_unpack
    import mdim_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEFAULT,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*FIELD_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_W-1:0]     out_a,
    output logic [FIELD_W-1:0]     out_b,
    output logic [$clog2(DEPTH):0] level
`ifdef MDIM_UNPACK_STATS_EN
    ,
    output logic [15:0]            word_cnt,
    output logic                   ovf_seen
`endif
);

    logic [2*FIELD_W-1:0] head_word;

    mdim_pair_fifo #(
        .FIELD_W (FIELD_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_word),
        .level     (level)
    );

    // The shared struct only fits the default field width; other widths slice directly.
    if (FIELD_W == FIELD_W_DEFAULT) begin : g_pair
        pair_t head;
        assign head  = head_word;
        assign out_a = head.a;
        assign out_b = head.b;
    end else begin : g_slice
        assign out_a = head_word[FIELD_W-1:0];
        assign out_b = head_word[2*FIELD_W-1:FIELD_W];
    end

`ifdef MDIM_UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            ovf_seen <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (in_valid && !in_ready) begin
                ovf_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mdim_unpack.sv
// Scoreboard bench for mdim_unpack; stats ports are checked when
// MDIM_UNPACK_STATS_EN is defined.
module tb_mdim_unpack;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [1:0] level;
`ifdef MDIM_UNPACK_STATS_EN
    logic [15:0] word_cnt;
    logic        ovf_seen;
`endif

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fails = 0;
    int         pop_count = 0;
    bit         rand_ready = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    mdim_unpack #(.FIELD_W(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .level     (level)
`ifdef MDIM_UNPACK_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .ovf_seen  (ovf_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offers one word and records its expected fields once the DUT takes it.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] ea,
                                 input logic [3:0] eb, output int waited);
        exp_t e;
        bit   done;
        done   = 1'b0;
        waited = 0;
        in_data  = data;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.a = ea;
                e.b = eb;
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL accept_timeout: word 0x%0h never accepted", data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every popped head against the scoreboard and checks hold stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("hold_valid", 32'(out_valid), 32'd1);
                    checkOutput("hold_data", 32'({out_b, out_a}), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("[TB] FAIL unexpected_pop: got a=0x%0h b=0x%0h, expected no word", out_a, out_b);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pop_a", 32'(out_a), 32'(e.a));
                        checkOutput("pop_b", 32'(out_b), 32'(e.b));
                    end
                    pop_count++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = {out_b, out_a};
            end
        end
    end

    initial begin
        int w;
        bit drained;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_a", 32'(out_a), 32'd0);
        checkOutput("rst_out_b", 32'(out_b), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        tick();

        // Single word with one-cycle latency.
        applyStimulus(8'hA5, 4'h5, 4'hA, w);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_a", 32'(out_a), 32'h5);
        checkOutput("single_b", 32'(out_b), 32'hA);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("single_empty", 32'(out_valid), 32'd0);
        tick();

        // Fill to full, then prove a held word is refused.
        applyStimulus(8'h12, 4'h2, 4'h1, w);
        applyStimulus(8'h34, 4'h4, 4'h3, w);
        in_data  = 8'h56;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("full_in_ready", 32'(in_ready), 32'd0);
            checkOutput("full_level", 32'(level), 32'd2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("after_pop_level", 32'(level), 32'd1);
        checkOutput("after_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("full_drained", 32'(level), 32'd0);
`ifdef MDIM_UNPACK_STATS_EN
        checkOutput("ovf_seen_set", 32'(ovf_seen), 32'd1);
        checkOutput("word_cnt", 32'(word_cnt), 32'(pop_count));
`endif
        tick();

        // Streaming at one word per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 4'(i), 4'h0, w);
            checkOutput("stream_no_wait", 32'(w), 32'd0);
            checkOutput("stream_level", 32'(level), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("stream_drained", 32'(out_valid), 32'd0);

        // Random backpressure over 100 words.
        rand_ready = 1'b1;
        out_ready  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 100; i++) begin
            logic [7:0] d;
            d = 8'(i);
            applyStimulus(d, d[3:0], d[7:4], w);
        end
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drained    = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
            tick();
        end
        @(negedge clk);
        checkOutput("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Reset with two words buffered.
        out_ready = 1'b0;
        applyStimulus(8'h77, 4'h7, 4'h7, w);
        applyStimulus(8'h8C, 4'hC, 4'h8, w);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_level", 32'(level), 32'd2);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_out_a", 32'(out_a), 32'd0);
        checkOutput("mid_rst_out_b", 32'(out_b), 32'd0);
`ifdef MDIM_UNPACK_STATS_EN
        checkOutput("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("mid_rst_ovf_seen", 32'(ovf_seen), 32'd0);
`endif
        tick();

        // Traffic resumes cleanly after reset.
        out_ready = 1'b1;
        applyStimulus(8'h3E, 4'hE, 4'h3, w);
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
